// File: rtl/vidc_clk_meter_regs_pkg.sv
// Shared definitions for the VIDC clock meter register block.
// Contents: register word indices, INFO identification constant,
// CTRL bit positions and the measurement FSM state encoding.
// Optional feature macro used by the top: VIDC_CLK_METER_PERIOD_EN.
package vidc_clk_meter_regs_pkg;

  localparam logic [3:0] W_INFO   = 4'd0;
  localparam logic [3:0] W_CTRL   = 4'd1;
  localparam logic [3:0] W_GATE   = 4'd2;
  localparam logic [3:0] W_RESULT = 4'd3;
  localparam logic [3:0] W_STATUS = 4'd4;
  localparam logic [3:0] W_PERIOD = 4'd5;

  localparam logic [31:0] INFO_VALUE = 32'hAD1C_0001;

  localparam int CTRL_LED_OVR   = 0;
  localparam int CTRL_LED_VAL   = 1;
  localparam int CTRL_TEST_CARD = 2;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } meter_state_e;

endpackage

// File: rtl/vidc_clk_meter_regs_edge_sync_detect.sv
// Two-flop synchroniser for an asynchronous input plus a history flop,
// producing a one-cycle pulse on each synchronised rising edge.
// Ports:
//   clk      in  sampling clock
//   reset_n  in  synchronous active-low reset
//   async_in in  asynchronous signal to sample
//   rise_o   out one-cycle pulse, high when sync=1 and history=0
// An input edge reaches rise_o two clocks after it is first sampled, so a
// counter fed by rise_o sees it on the third clock edge.
module vidc_clk_meter_regs_edge_sync_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/vidc_clk_meter_regs.sv
// VIDC clock meter / control register block on the SPI register bus.
// Holds LED override and test-card controls and measures meas_clk by
// counting its synchronised rising edges over a gate window of sys clocks.
// Ports:
//   clk, reset_n           sys clock, synchronous active-low reset
//   reg_select             access targets this block
//   reg_wstrobe            single-cycle write strobe
//   reg_addr[5:0]          byte address, [5:2] selects the word
//   reg_wdata[31:0]        write data
//   reg_rdata[31:0]        combinational read data (0 when not selected)
//   meas_clk               asynchronous clock being measured
//   led_ovr, led_val       LED override enable / level
//   test_card_en           video test-card enable
// Bus protocol: a write happens on every clock where reg_select and
// reg_wstrobe are both high; there is no back-pressure. Reads are pure
// combinational decodes with no side effects.
// Optional feature macro: VIDC_CLK_METER_PERIOD_EN adds the PERIOD word.
module vidc_clk_meter_regs
  import vidc_clk_meter_regs_pkg::*;
#(
  parameter int CLK_RATE     = 62500000,
  parameter int GATE_DEFAULT = 62500,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_select,
  input  logic        reg_wstrobe,
  input  logic [5:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        meas_clk,
  output logic        led_ovr,
  output logic        led_val,
  output logic        test_card_en
);

  if (CLK_RATE <= 0 || GATE_DEFAULT <= 0 || CNT_W < 1 || CNT_W > 24) begin : g_bad_params
    $error("vidc_clk_meter_regs: invalid parameter values");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       word;
  logic             wr_ctrl, wr_gate, rise;
  logic [CNT_W-1:0] cnt_plus;
  logic             sat_hit;
  logic             unused_bits;

  meter_state_e     state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [23:0]      gate_q, gate_d;
  logic [23:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             present_q, present_d;
  logic             stat_sat_q, stat_sat_d;
  logic [7:0]       win_cnt_q, win_cnt_d;

  assign word        = reg_addr[5:2];
  assign wr_ctrl     = reg_select && reg_wstrobe && (word == W_CTRL);
  assign wr_gate     = reg_select && reg_wstrobe && (word == W_GATE);
  assign unused_bits = ^{reg_addr[1:0], reg_wdata[31:24]};

  vidc_clk_meter_regs_edge_sync_detect u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (meas_clk),
    .rise_o   (rise)
  );

  // Saturating edge increment; also used in LATCH so that an edge seen in
  // that cycle lands in the latched result.
  always_comb begin
    sat_hit  = rise && (&edge_cnt_q);
    cnt_plus = edge_cnt_q;
    if (rise && !(&edge_cnt_q)) cnt_plus = edge_cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    gate_d     = gate_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    result_d   = result_q;
    sat_d      = sat_q;
    valid_d    = valid_q;
    present_d  = present_q;
    stat_sat_d = stat_sat_q;
    win_cnt_d  = win_cnt_q;

    if (wr_ctrl) ctrl_d = reg_wdata[2:0];

    case (state_q)
      ST_ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        gate_cnt_d = gate_cnt_q + 24'd1;
        edge_cnt_d = cnt_plus;
        sat_d      = sat_q | sat_hit;
        if (gate_cnt_q == gate_q - 24'd1) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        result_d   = cnt_plus;
        valid_d    = 1'b1;
        present_d  = (cnt_plus != '0);
        stat_sat_d = sat_q | sat_hit;
        win_cnt_d  = win_cnt_q + 8'd1;
        state_d    = ST_ARM;
      end
      default: state_d = ST_ARM;
    endcase

    // A new gate restarts measurement; it overrides a coincident LATCH for
    // the status fields but the result register still takes the latch.
    if (wr_gate) begin
      gate_d     = (reg_wdata[23:0] == 24'd0) ? 24'd1 : reg_wdata[23:0];
      state_d    = ST_ARM;
      valid_d    = 1'b0;
      sat_d      = 1'b0;
      stat_sat_d = 1'b0;
      win_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_ARM;
      ctrl_q     <= 3'd0;
      gate_q     <= 24'(GATE_DEFAULT);
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      present_q  <= 1'b0;
      stat_sat_q <= 1'b0;
      win_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      gate_q     <= gate_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      result_q   <= result_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      present_q  <= present_d;
      stat_sat_q <= stat_sat_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

`ifdef VIDC_CLK_METER_PERIOD_EN
  // Shortest spacing between consecutive edges within the window, in sys
  // clocks. per_cnt restarts at 1 on each edge so it holds the spacing when
  // the next edge arrives.
  logic [23:0] per_cnt_q, per_cnt_d;
  logic [23:0] per_min_q, per_min_d, per_min_now;
  logic [23:0] period_q, period_d;
  logic        per_seen_q, per_seen_d;

  always_comb begin
    per_min_now = per_min_q;
    if (rise && per_seen_q && (per_cnt_q < per_min_q)) per_min_now = per_cnt_q;
    per_cnt_d  = per_cnt_q;
    per_min_d  = per_min_q;
    per_seen_d = per_seen_q;
    period_d   = period_q;
    case (state_q)
      ST_ARM: begin
        per_cnt_d  = 24'd0;
        per_min_d  = 24'hFF_FFFF;
        per_seen_d = 1'b0;
      end
      ST_COUNT: begin
        if (rise)            per_cnt_d = 24'd1;
        else if (!(&per_cnt_q)) per_cnt_d = per_cnt_q + 24'd1;
        per_seen_d = per_seen_q | rise;
        per_min_d  = per_min_now;
      end
      ST_LATCH: period_d = per_min_now;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      per_cnt_q  <= 24'd0;
      per_min_q  <= 24'hFF_FFFF;
      per_seen_q <= 1'b0;
      period_q   <= 24'd0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      per_min_q  <= per_min_d;
      per_seen_q <= per_seen_d;
      period_q   <= period_d;
    end
  end
`endif

  always_comb begin
    reg_rdata = 32'd0;
    if (reg_select) begin
      case (word)
        W_INFO:   reg_rdata = INFO_VALUE;
        W_CTRL:   reg_rdata = {29'd0, ctrl_q};
        W_GATE:   reg_rdata = {8'd0, gate_q};
        W_RESULT: reg_rdata = 32'(result_q);
        W_STATUS: reg_rdata = {16'd0, win_cnt_q, 5'd0, stat_sat_q, present_q, valid_q};
`ifdef VIDC_CLK_METER_PERIOD_EN
        W_PERIOD: reg_rdata = {8'd0, period_q};
`endif
        default:  reg_rdata = 32'd0;
      endcase
    end
  end

  assign led_ovr      = ctrl_q[CTRL_LED_OVR];
  assign led_val      = ctrl_q[CTRL_LED_VAL];
  assign test_card_en = ctrl_q[CTRL_TEST_CARD];

endmodule

// File: tb/tb_vidc_clk_meter_regs.sv
// Directed bench for vidc_clk_meter_regs: a default instance plus a CNT_W=4
// instance sharing the register bus but with its own 20 MHz meas clock.
module tb_vidc_clk_meter_regs;
  import vidc_clk_meter_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_select = 1'b0;
  logic        reg_wstrobe = 1'b0;
  logic [5:0]  reg_addr = 6'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        meas_clk = 1'b0;
  logic        meas_clk4 = 1'b0;
  int          meas_half = 0;

  logic [31:0] reg_rdata, reg_rdata4;
  logic        led_ovr, led_val, test_card_en;
  logic        led_ovr4, led_val4, test_card_en4;

  int checks = 0;
  int passed = 0;

  // ---------------- clock / reset ----------------
  // sys clock 62.5 MHz: 16000 time units per period
  always #8000 clk = ~clk;

  always begin
    if (meas_half == 0) begin
      meas_clk = 1'b0;
      #1000;
    end else begin
      #(meas_half) meas_clk = ~meas_clk;
    end
  end

  // 20 MHz for the narrow-counter instance
  always #25000 meas_clk4 = ~meas_clk4;

  vidc_clk_meter_regs dut (
    .clk(clk), .reset_n(reset_n), .reg_select(reg_select), .reg_wstrobe(reg_wstrobe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .meas_clk(meas_clk), .led_ovr(led_ovr), .led_val(led_val), .test_card_en(test_card_en)
  );

  vidc_clk_meter_regs #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .reg_select(reg_select), .reg_wstrobe(reg_wstrobe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata4),
    .meas_clk(meas_clk4), .led_ovr(led_ovr4), .led_val(led_val4), .test_card_en(test_card_en4)
  );

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    reg_select  = 1'b1;
    reg_wstrobe = 1'b1;
    reg_addr    = {w, 2'b00};
    reg_wdata   = d;
    @(negedge clk);
    reg_select  = 1'b0;
    reg_wstrobe = 1'b0;
  endtask

  // Called at a negedge; samples the combinational read 1 unit later.
  task automatic rd(input logic [3:0] w, output logic [31:0] v, output logic [31:0] v4);
    reg_select = 1'b1;
    reg_addr   = {w, 2'b00};
    #1;
    v  = reg_rdata;
    v4 = reg_rdata4;
    reg_select = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0]  w_tab[7]   = '{W_INFO, W_CTRL, W_GATE, W_RESULT, W_STATUS, W_PERIOD, 4'd7};
    logic [31:0] exp_tab[7] = '{32'hAD1C_0001, 32'd0, 32'h0000_F424, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] v, v4;
    meas_half = 20833;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd(w_tab[i], v, v4);
      checks++;
      if (v !== exp_tab[i]) $display("FAIL reset_word%0d: got %h expected %h", w_tab[i], v, exp_tab[i]);
      else passed++;
    end
    checks++;
    if ({led_ovr, led_val, test_card_en} !== 3'b000)
      $display("FAIL reset_outputs: got %b expected 000", {led_ovr, led_val, test_card_en});
    else passed++;
  endtask

  task automatic test_bus_decode();
    logic [31:0] v, v4;
    @(negedge clk);
    reg_addr = {W_INFO, 2'b00};
    reg_select = 1'b0;
    #1;
    checks++;
    if (reg_rdata !== 32'd0) $display("FAIL rdata_unselected: got %h expected 0", reg_rdata);
    else passed++;
    wr(W_INFO, 32'h1234_5678);
    wr(W_RESULT, 32'h0000_FFFF);
    wr(4'd9, 32'hFFFF_FFFF);
    rd(W_INFO, v, v4);
    checks++;
    if (v !== 32'hAD1C_0001) $display("FAIL info_ro: got %h expected ad1c0001", v);
    else passed++;
    rd(W_RESULT, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL result_ro: got %h expected 0", v);
    else passed++;
    rd(4'd9, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL unmapped_word9: got %h expected 0", v);
    else passed++;
  endtask

  task automatic test_freq_24m();
    logic [31:0] v, v4;
    logic found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL freq24_timeout: got valid=0 expected valid=1");
    else passed++;
    rd(W_RESULT, v, v4);
    checks++;
    if (v < 32'd23999 || v > 32'd24001) $display("FAIL freq24_result: got %0d expected 24000+-1", v);
    else passed++;
    rd(W_STATUS, v, v4);
    checks++;
    if (v !== 32'h0000_0103) $display("FAIL freq24_status: got %h expected 00000103", v);
    else passed++;
  endtask

  task automatic test_stopped_clk();
    logic [31:0] v, v4;
    logic found = 1'b0;
    meas_half = 0;
    repeat (10) @(negedge clk);
    wr(W_GATE, 32'd1000);
    rd(W_GATE, v, v4);
    checks++;
    if (v !== 32'd1000) $display("FAIL gate_readback: got %h expected 000003e8", v);
    else passed++;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL stopped_timeout: got valid=0 expected valid=1");
    else passed++;
    rd(W_RESULT, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL stopped_result: got %h expected 0", v);
    else passed++;
    rd(W_STATUS, v, v4);
    checks++;
    if (v !== 32'h0000_0101) $display("FAIL stopped_status: got %h expected 00000101", v);
    else passed++;
  endtask

  task automatic test_ctrl();
    logic [31:0] v, v4;
    logic found = 1'b0;
    wr(W_CTRL, 32'h0000_0007);
    checks++;
    if ({led_ovr, led_val, test_card_en} !== 3'b111)
      $display("FAIL ctrl_outputs_on: got %b expected 111", {led_ovr, led_val, test_card_en});
    else passed++;
    rd(W_CTRL, v, v4);
    checks++;
    if (v !== 32'd7) $display("FAIL ctrl_readback: got %h expected 7", v);
    else passed++;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[15:8] == 8'd2) found = 1'b1;
    end
    checks++;
    if (v !== 32'h0000_0201) $display("FAIL ctrl_meas_undisturbed: got %h expected 00000201", v);
    else passed++;
    wr(W_CTRL, 32'hFFFF_FFF8);
    checks++;
    if ({led_ovr, led_val, test_card_en} !== 3'b000)
      $display("FAIL ctrl_outputs_off: got %b expected 000", {led_ovr, led_val, test_card_en});
    else passed++;
    rd(W_CTRL, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL ctrl_upper_bits: got %h expected 0", v);
    else passed++;
  endtask

  task automatic test_gate_zero();
    logic [31:0] v, v4;
    int k = 0;
    wr(W_GATE, 32'd0);
    rd(W_GATE, v, v4);
    checks++;
    if (v !== 32'd1) $display("FAIL gate_zero_readback: got %h expected 1", v);
    else passed++;
    rd(W_STATUS, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL gate_zero_status_clear: got %h expected 0", v);
    else passed++;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) k = i;
    end
    checks++;
    if (k != 3) $display("FAIL gate_one_window_len: got %0d expected 3", k);
    else passed++;
    rd(W_RESULT, v, v4);
    checks++;
    if (v > 32'd1) $display("FAIL gate_one_result: got %h expected 0 or 1", v);
    else passed++;
  endtask

  task automatic test_gate_midwindow();
    logic [31:0] v, v4;
    int k = 0;
    logic found = 1'b0;
    wr(W_GATE, 32'd100);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) found = 1'b1;
    end
    repeat (40) @(negedge clk);
    rd(W_STATUS, v, v4);
    checks++;
    if (v[0] !== 1'b1) $display("FAIL gate100_valid_before: got %b expected 1", v[0]);
    else passed++;
    wr(W_GATE, 32'd100);
    rd(W_STATUS, v, v4);
    checks++;
    if (v[0] !== 1'b0) $display("FAIL gate100_valid_cleared: got %b expected 0", v[0]);
    else passed++;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) k = i;
    end
    checks++;
    if (k != 102) $display("FAIL gate100_window_len: got %0d expected 102", k);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [31:0] v, v4;
    logic found = 1'b0;
    wr(W_GATE, 32'd100);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v4[0]) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL sat_timeout: got valid=0 expected valid=1");
    else passed++;
    rd(W_RESULT, v, v4);
    checks++;
    if (v4 !== 32'd15) $display("FAIL sat_result: got %0d expected 15", v4);
    else passed++;
    rd(W_STATUS, v, v4);
    checks++;
    if (v4 !== 32'h0000_0107) $display("FAIL sat_status: got %h expected 00000107", v4);
    else passed++;
  endtask

  task automatic test_reset_mid_count();
    logic [3:0]  w_tab[5]   = '{W_INFO, W_CTRL, W_GATE, W_RESULT, W_STATUS};
    logic [31:0] exp_tab[5] = '{32'hAD1C_0001, 32'd0, 32'h0000_F424, 32'd0, 32'd0};
    logic [31:0] v, v4;
    logic found = 1'b0;
    meas_half = 20833;
    wr(W_CTRL, 32'd7);
    wr(W_GATE, 32'd100);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      rd(W_STATUS, v, v4);
      if (v[0]) found = 1'b1;
    end
    rd(W_RESULT, v, v4);
    checks++;
    if (v < 32'd37 || v > 32'd40) $display("FAIL pre_reset_result: got %0d expected 37..40", v);
    else passed++;
    repeat (30) @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      rd(w_tab[i], v, v4);
      checks++;
      if (v !== exp_tab[i]) $display("FAIL midreset_word%0d: got %h expected %h", w_tab[i], v, exp_tab[i]);
      else passed++;
    end
    checks++;
    if ({led_ovr, led_val, test_card_en} !== 3'b000)
      $display("FAIL midreset_outputs: got %b expected 000", {led_ovr, led_val, test_card_en});
    else passed++;
    rd(W_STATUS, v, v4);
    checks++;
    if (v4 !== 32'd0) $display("FAIL midreset_status4: got %h expected 0", v4);
    else passed++;
    repeat (200) @(negedge clk);
    rd(W_STATUS, v, v4);
    checks++;
    if (v !== 32'd0) $display("FAIL midreset_no_partial: got %h expected 0", v);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bus_decode();
    test_freq_24m();
    test_stopped_clk();
    test_ctrl();
    test_gate_zero();
    test_gate_midwindow();
    test_saturation();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
